// File: rtl/btn_conditioner_multi.sv
// btn_conditioner_multi
//   Conditions NUM_BTNS raw push-buttons through one shared millisecond prescaler.
//   Each channel has a 2-FF synchroniser, polarity fix, tick-based debounce, and a
//   hold FSM that produces long-press and auto-repeat strobes.
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_in       raw asynchronous button pins
//   btn_level    debounced level, 1 = pressed
//   btn_press    1-cycle strobe on debounced 0->1
//   btn_release  1-cycle strobe on debounced 1->0
//   btn_long     1-cycle strobe after LONG_PRESS_MS held
//   btn_repeat   1-cycle strobe every REPEAT_MS after btn_long while held
//
// Hold FSM states
//   state     | meaning
//   ST_IDLE   | debounced level is 0
//   ST_HELD   | pressed, counting ms towards the long-press threshold
//   ST_REPEAT | long press reported, counting ms between repeat strobes
module btn_conditioner_multi #(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int NUM_BTNS      = 5,
   parameter int DEBOUNCE_MS   = 10,
   parameter int LONG_PRESS_MS = 500,
   parameter int REPEAT_MS     = 100,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_BTNS-1:0] btn_in,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_release,
   output logic [NUM_BTNS-1:0] btn_long,
   output logic [NUM_BTNS-1:0] btn_repeat
);

   localparam int TICK_DIV = CLK_FREQ / 1000;
   localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW       = $clog2(DEBOUNCE_MS + 1);
   localparam int HMAX     = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
   localparam int HW       = $clog2(HMAX + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
   localparam logic [HW-1:0] LP_LAST   = HW'(LONG_PRESS_MS - 1);
   localparam logic [HW-1:0] RP_LAST   = HW'(REPEAT_MS - 1);
   localparam bit            RP_ON     = (REPEAT_MS != 0);

   localparam logic [NUM_BTNS-1:0] INACTIVE = ACTIVE_LOW ? '1 : '0;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HELD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   logic [TW-1:0]       tick_cnt;
   logic                tick;
   logic [NUM_BTNS-1:0] s0;
   logic [NUM_BTNS-1:0] s1;
   logic [NUM_BTNS-1:0] synced;
   logic [NUM_BTNS-1:0] stable_v;
   logic [NUM_BTNS-1:0] long_v;
   logic [NUM_BTNS-1:0] rep_v;

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Sync FFs start at the idle pin level so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0 <= INACTIVE;
         s1 <= INACTIVE;
      end else begin
         s0 <= btn_in;
         s1 <= s0;
      end
   end

   assign synced = s1 ^ INACTIVE;

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
      logic [DW-1:0] db_cnt;
      logic          stable;
      logic          mism;
      logic          rise;
      logic          fall;
      logic [1:0]    state;
      logic [HW-1:0] hold_cnt;
      logic          long_ev;
      logic          rep_ev;
      logic          long_q;
      logic          rep_q;

      assign mism = synced[g] ^ stable;

      // Flip events are decoded one edge early so the FSM sees a release on the
      // same tick as a threshold and can suppress that strobe.
      always_comb begin
         rise = 1'b0;
         fall = 1'b0;
         if (tick && mism && (db_cnt == DB_LAST)) begin
            rise = synced[g];
            fall = ~synced[g];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            db_cnt <= '0;
            stable <= 1'b0;
         end else if (!mism) begin
            db_cnt <= '0;
         end else if (tick) begin
            if (db_cnt == DB_LAST) begin
               stable <= synced[g];
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end
      end

      always_comb begin
         long_ev = 1'b0;
         rep_ev  = 1'b0;
         if (tick && !fall) begin
            if ((state == ST_HELD) && (hold_cnt == LP_LAST))
               long_ev = 1'b1;
            if (RP_ON && (state == ST_REPEAT) && (hold_cnt == RP_LAST))
               rep_ev = 1'b1;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            long_q   <= 1'b0;
            rep_q    <= 1'b0;
         end else begin
            long_q <= long_ev;
            rep_q  <= rep_ev;
            if (fall) begin
               state    <= ST_IDLE;
               hold_cnt <= '0;
            end else begin
               case (state)
                  ST_IDLE: begin
                     if (rise) begin
                        state    <= ST_HELD;
                        hold_cnt <= '0;
                     end
                  end
                  ST_HELD: begin
                     if (long_ev) begin
                        state    <= ST_REPEAT;
                        hold_cnt <= '0;
                     end else if (tick) begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
                  ST_REPEAT: begin
                     if (rep_ev) begin
                        hold_cnt <= '0;
                     end else if (tick && RP_ON) begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
                  default: begin
                     state    <= ST_IDLE;
                     hold_cnt <= '0;
                  end
               endcase
            end
         end
      end

      assign stable_v[g] = stable;
      assign long_v[g]   = long_q;
      assign rep_v[g]    = rep_q;
   end

   // All strobes leave one cycle after the internal event, aligned with btn_level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         btn_long    <= '0;
         btn_repeat  <= '0;
      end else begin
         btn_level   <= stable_v;
         btn_press   <= stable_v & ~btn_level;
         btn_release <= ~stable_v & btn_level;
         btn_long    <= long_v;
         btn_repeat  <= rep_v;
      end
   end

endmodule

// File: tb/tb_btn_conditioner_multi.sv
module tb_btn_conditioner_multi;

   localparam int CF = 10_000;
   localparam int T  = 10;
   localparam int NB = 2;
   localparam int DB = 3;
   localparam int LP = 5;
   localparam int RP = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NB-1:0] btn_a = '0;
   logic [NB-1:0] btn_b = '1;
   logic [NB-1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
   logic [NB-1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   btn_conditioner_multi #(.CLK_FREQ(CF), .NUM_BTNS(NB), .DEBOUNCE_MS(DB),
      .LONG_PRESS_MS(LP), .REPEAT_MS(RP), .ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_a), .btn_level(lvl_a), .btn_press(prs_a),
      .btn_release(rel_a), .btn_long(lng_a), .btn_repeat(rep_a));

   btn_conditioner_multi #(.CLK_FREQ(CF), .NUM_BTNS(NB), .DEBOUNCE_MS(DB),
      .LONG_PRESS_MS(LP), .REPEAT_MS(RP), .ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_b), .btn_level(lvl_b), .btn_press(prs_b),
      .btn_release(rel_b), .btn_long(lng_b), .btn_repeat(rep_b));

   // Reference model: event timestamps in edges since reset, tick counts by arithmetic.
   int            k;
   logic          m_s0 [2][NB];
   logic          m_s1 [2][NB];
   logic          m_st [2][NB];
   int            m_mis [2][NB];
   int            m_flip [2][NB];
   int            m_rise [2][NB];
   int            m_long [2][NB];
   int            m_rep [2][NB];
   logic          m_pin, m_syn;
   int            m_n;
   logic [NB-1:0] e_lvl [2];
   logic [NB-1:0] e_prs [2];
   logic [NB-1:0] e_rel [2];
   logic [NB-1:0] e_lng [2];
   logic [NB-1:0] e_rep [2];

   function automatic int nticks(int a, int b);
      return (b + 1) / T - (a + 1) / T;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k = 0;
         for (int i = 0; i < 2; i++) begin
            e_lvl[i] = '0; e_prs[i] = '0; e_rel[i] = '0; e_lng[i] = '0; e_rep[i] = '0;
            for (int c = 0; c < NB; c++) begin
               m_s0[i][c] = (i == 1);
               m_s1[i][c] = (i == 1);
               m_st[i][c] = 1'b0;
               m_mis[i][c] = -1;
               m_flip[i][c] = -10;
               m_rise[i][c] = -1;
               m_long[i][c] = -1;
               m_rep[i][c] = -1;
            end
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NB; c++) begin
               m_pin = (i == 0) ? btn_a[c] : btn_b[c];
               m_syn = m_s1[i][c] ^ (i == 1);
               e_lvl[i][c] = m_st[i][c];
               e_prs[i][c] = (m_flip[i][c] == k - 1) && m_st[i][c];
               e_rel[i][c] = (m_flip[i][c] == k - 1) && !m_st[i][c];
               e_lng[i][c] = (m_long[i][c] == k);
               e_rep[i][c] = (m_rep[i][c] == k);
               if (m_syn == m_st[i][c]) begin
                  m_mis[i][c] = -1;
               end else begin
                  if (m_mis[i][c] < 0) m_mis[i][c] = k;
                  if ((k % T == T - 1) && nticks(m_mis[i][c] - 1, k) == DB) begin
                     m_st[i][c] = m_syn;
                     m_flip[i][c] = k;
                     m_mis[i][c] = -1;
                     m_rise[i][c] = m_syn ? k : -1;
                  end
               end
               if (m_st[i][c] && m_rise[i][c] >= 0 && (k % T == T - 1)) begin
                  m_n = nticks(m_rise[i][c], k);
                  if (m_n == LP) m_long[i][c] = k + 1;
                  else if (RP > 0 && m_n > LP && (m_n - LP) % RP == 0) m_rep[i][c] = k + 1;
               end
               m_s1[i][c] = m_s0[i][c];
               m_s0[i][c] = m_pin;
            end
         end
         k++;
      end
   end

   logic [5*NB-1:0] obs_a, obs_b, exp_a, exp_b;
   assign obs_a = {lvl_a, prs_a, rel_a, lng_a, rep_a};
   assign obs_b = {lvl_b, prs_b, rel_b, lng_b, rep_b};
   assign exp_a = {e_lvl[0], e_prs[0], e_rel[0], e_lng[0], e_rep[0]};
   assign exp_b = {e_lvl[1], e_prs[1], e_rel[1], e_lng[1], e_rep[1]};

   task automatic test_reset();
      rst_n = 1'b0; btn_a = '0; btn_b = '1;
      repeat (3) @(negedge clk);
      checks++;
      if (obs_a !== '0 || obs_b !== '0) begin
         errors++; $display("FAIL reset_outputs: dut=%h/%h want=000/000", obs_a, obs_b);
      end
      rst_n = 1'b1;
      repeat (30) begin
         @(negedge clk); checks++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL reset_idle: dut=%h/%h model=%h/%h", obs_a, obs_b, exp_a, exp_b);
         end
      end
   endtask

   task automatic test_bounce();
      int last_edge = 0, press_at = -1, n_bounce = 0, n_press = 0;
      for (int c = 0; c < 130; c++) begin
         @(negedge clk); checks++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL bounce_cycle: dut=%h/%h model=%h/%h", obs_a, obs_b, exp_a, exp_b);
         end
         if (c < 60) begin
            if (|{prs_a[0], rel_a[0]}) n_bounce++;
            if (c % 7 == 0) begin btn_a[0] = ~btn_a[0]; last_edge = c; end
         end else if (prs_a[0]) begin
            n_press++; press_at = c;
         end
      end
      checks++;
      if (n_bounce != 0) begin errors++; $display("FAIL bounce_quiet: strobes=%0d want=0", n_bounce); end
      checks++;
      if (n_press != 1) begin errors++; $display("FAIL bounce_press_count: got=%0d want=1", n_press); end
      checks++;
      if (press_at - last_edge < 23 || press_at - last_edge > 33) begin
         errors++; $display("FAIL bounce_latency: got=%0d want=23..33", press_at - last_edge);
      end
      checks++;
      if (lvl_a[0] !== 1'b1) begin errors++; $display("FAIL bounce_level: got=%b want=1", lvl_a[0]); end
      btn_a[0] = 1'b0;
      repeat (60) begin
         @(negedge clk); checks++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL bounce_settle: dut=%h/%h model=%h/%h", obs_a, obs_b, exp_a, exp_b);
         end
      end
   endtask

   task automatic test_clean();
      int n_press = 0, n_rel = 0, ch1 = 0, p_at = -1, r_at = -1;
      for (int c = 0; c < 160; c++) begin
         @(negedge clk); checks++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL clean_cycle: dut=%h/%h model=%h/%h", obs_a, obs_b, exp_a, exp_b);
         end
         if (prs_a[0]) begin n_press++; p_at = c; end
         if (rel_a[0]) begin n_rel++; r_at = c; end
         if (|{lvl_a[1], prs_a[1], rel_a[1], lng_a[1], rep_a[1]}) ch1++;
         if (c == 0) btn_a[0] = 1'b1;
         if (c == 100) btn_a[0] = 1'b0;
      end
      checks++;
      if (n_press != 1 || n_rel != 1) begin
         errors++; $display("FAIL clean_counts: press=%0d release=%0d want=1/1", n_press, n_rel);
      end
      checks++;
      if (p_at < 24 || p_at > 33 || r_at - 100 < 24 || r_at - 100 > 33) begin
         errors++; $display("FAIL clean_latency: press=%0d release=%0d want=24..33", p_at, r_at - 100);
      end
      checks++;
      if (ch1 != 0) begin errors++; $display("FAIL clean_ch1_quiet: active=%0d want=0", ch1); end
   endtask

   task automatic test_long_repeat();
      int p_at = -1, l_at = -1, last = -1, n_long = 0, n_rep = 0, r_at = -1, late = 0;
      for (int c = 0; c < 270; c++) begin
         @(negedge clk); checks++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL long_cycle: dut=%h/%h model=%h/%h", obs_a, obs_b, exp_a, exp_b);
         end
         if (prs_a[1]) p_at = c;
         if (rel_a[1]) r_at = c;
         if (r_at >= 0 && (lng_a[1] || rep_a[1]) && !rel_a[1]) late++;
         if (lng_a[1]) begin n_long++; l_at = c; last = c; end
         if (rep_a[1]) begin
            n_rep++; checks++;
            if (c - last != 20) begin errors++; $display("FAIL repeat_gap: got=%0d want=20", c - last); end
            last = c;
         end
         if (c == 0) btn_a[1] = 1'b1;
         if (c == 200) btn_a[1] = 1'b0;
      end
      checks++;
      if (n_long != 1 || l_at - p_at != 50) begin
         errors++; $display("FAIL long_timing: count=%0d delay=%0d want=1/50", n_long, l_at - p_at);
      end
      checks++;
      if (n_rep < 3 || r_at < 0) begin
         errors++; $display("FAIL repeat_count: repeats=%0d release_at=%0d want>=3/released", n_rep, r_at);
      end
      checks++;
      if (late != 0) begin errors++; $display("FAIL strobe_after_release: got=%0d want=0", late); end
   endtask

   task automatic test_short_hold();
      int n_long = 0, n_press = 0, n_rel = 0;
      for (int h = 40; h <= 56; h++) begin
         if (h > 40 && h < 44) continue;
         for (int c = 0; c < h + 70; c++) begin
            @(negedge clk); checks++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
               errors++; $display("FAIL short_cycle h=%0d: dut=%h/%h model=%h/%h", h, obs_a, obs_b, exp_a, exp_b);
            end
            if (h == 40) begin
               if (lng_a[0] || rep_a[0]) n_long++;
               if (prs_a[0]) n_press++;
               if (rel_a[0]) n_rel++;
            end
            if (c == 0) btn_a[0] = 1'b1;
            if (c == h) btn_a[0] = 1'b0;
         end
         if (h == 40) begin
            checks++;
            if (n_long != 0 || n_press != 1 || n_rel != 1) begin
               errors++; $display("FAIL short_hold: long=%0d press=%0d release=%0d want=0/1/1", n_long, n_press, n_rel);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int p_at = -1, early_rel = 0;
      btn_a[1] = 1'b1;
      for (int c = 0; c < 110; c++) begin
         @(negedge clk); checks++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL mid_cycle: dut=%h/%h model=%h/%h", obs_a, obs_b, exp_a, exp_b);
         end
      end
      checks++;
      if (lvl_a[1] !== 1'b1) begin errors++; $display("FAIL mid_held: level=%b want=1", lvl_a[1]); end
      #2 rst_n = 1'b0;
      #1 checks++;
      if (obs_a !== '0 || obs_b !== '0) begin
         errors++; $display("FAIL async_reset: dut=%h/%h want=000/000", obs_a, obs_b);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk); checks++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL after_reset: dut=%h/%h model=%h/%h", obs_a, obs_b, exp_a, exp_b);
         end
         if (prs_a[1] && p_at < 0) p_at = c;
         if (rel_a[1] && p_at < 0) early_rel++;
      end
      checks++;
      if (p_at < 0 || p_at + 1 > 3 * T + 3 || early_rel != 0) begin
         errors++; $display("FAIL reset_repress: press_at=%0d early_release=%0d want<=%0d/0", p_at + 1, early_rel, 3 * T + 3);
      end
      btn_a[1] = 1'b0;
      repeat (60) begin
         @(negedge clk); checks++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL mid_settle: dut=%h/%h model=%h/%h", obs_a, obs_b, exp_a, exp_b);
         end
      end
   endtask

   task automatic test_active_low();
      int idle = 0, n_press = 0, n_rel = 0;
      for (int c = 0; c < 140; c++) begin
         @(negedge clk); checks++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL al_cycle: dut=%h/%h model=%h/%h", obs_a, obs_b, exp_a, exp_b);
         end
         if (c < 20 && obs_b !== '0) idle++;
         if (prs_b[0]) n_press++;
         if (rel_b[0]) n_rel++;
         if (c == 20) btn_b[0] = 1'b0;
         if (c == 60) btn_b[0] = 1'b1;
      end
      checks++;
      if (idle != 0) begin errors++; $display("FAIL al_idle: active=%0d want=0", idle); end
      checks++;
      if (n_press != 1 || n_rel != 1) begin
         errors++; $display("FAIL al_strobes: press=%0d release=%0d want=1/1", n_press, n_rel);
      end
   endtask

   task automatic test_random();
      int dwell [4];
      for (int j = 0; j < 4; j++) dwell[j] = 1;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk); checks++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL random_cycle %0d: dut=%h/%h model=%h/%h", c, obs_a, obs_b, exp_a, exp_b);
         end
         for (int j = 0; j < 4; j++) begin
            dwell[j]--;
            if (dwell[j] == 0) begin
               dwell[j] = (c > 1400) ? 200 : int'($urandom_range(1, 70));
               if (j < 2) btn_a[j] = (c > 1400) ? 1'b0 : 1'($urandom);
               else btn_b[j-2] = (c > 1400) ? 1'b1 : 1'($urandom);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_clean();
      test_long_repeat();
      test_short_hold();
      test_reset_mid();
      test_active_low();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
